// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the SPI burst controller: FSM states, default
// chip-select timing and the cpol/cpha mode encoding.
package spi_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_LOAD,
    ST_WAIT,
    ST_HOLD,
    ST_GAP
  } state_t;

  localparam int DEF_CS_SETUP_CYC = 50;
  localparam int DEF_CS_HOLD_CYC  = 50;
  localparam int DEF_CS_GAP_CYC   = 100;

  localparam int MODE_CPHA_BIT = 0;
  localparam int MODE_CPOL_BIT = 1;

  typedef logic [1:0] spi_mode_t;

  function automatic spi_mode_t make_mode(input logic cpol, input logic cpha);
    spi_mode_t m;
    m                = '0;
    m[MODE_CPOL_BIT] = cpol;
    m[MODE_CPHA_BIT] = cpha;
    return m;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted req at or above ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic                       valid,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    valid = 1'b0;
    idx   = ptr;
    sum   = '0;
    cand  = '0;
    // Walk offsets downward so the nearest requester above ptr is written last.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      sum = {1'b0, ptr} + (IDX_W + 1)'(i);
      if (sum >= (IDX_W + 1)'(NUM_REQ)) sum = sum - (IDX_W + 1)'(NUM_REQ);
      cand = sum[IDX_W-1:0];
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/spi_burst_arbiter.sv
// Shares one single-byte SPI master between NUM_REQ requesters, running a
// multi-byte burst per round-robin grant with its own chip-select timing.
module spi_burst_arbiter
  import spi_ctrl_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int LEN_W        = 4,
  parameter int CS_SETUP_CYC = DEF_CS_SETUP_CYC,
  parameter int CS_HOLD_CYC  = DEF_CS_HOLD_CYC,
  parameter int CS_GAP_CYC   = DEF_CS_GAP_CYC
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
  input  logic [NUM_REQ-1:0]       req_cpol,
  input  logic [NUM_REQ-1:0]       req_cpha,
  input  logic [NUM_REQ*8-1:0]     req_tx_data,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       tx_ack,
  output logic [NUM_REQ-1:0]       rx_valid,
  output logic [7:0]               rx_data,
  output logic [NUM_REQ-1:0]       txn_done,
  output logic [NUM_REQ-1:0]       ss_n,
  output logic                     m_start,
  output logic [7:0]               m_tx_data,
  output logic                     m_cpol,
  output logic                     m_cpha,
  input  logic [7:0]               m_rx_data,
  input  logic                     m_done,
  input  logic                     m_ready
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int MAX_CYC = max3(CS_SETUP_CYC, CS_HOLD_CYC, CS_GAP_CYC);
  localparam int CNT_W   = (MAX_CYC < 1) ? 1 : $clog2(MAX_CYC + 1);

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   byte_cnt;
  logic [CNT_W-1:0]   cnt;
  logic               phase_last;
  logic [NUM_REQ-1:0] arb_onehot;
  spi_mode_t          arb_mode;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req   (req),
    .ptr   (rr_ptr),
    .valid (arb_valid),
    .idx   (arb_idx)
  );

  // A timed phase ends on the cycle its count is reached; a limit of 0 behaves as 1.
  always_comb begin
    arb_onehot = NUM_REQ'(1) << arb_idx;
    arb_mode   = make_mode(req_cpol[arb_idx], req_cpha[arb_idx]);
    phase_last = 1'b0;
    case (state)
      ST_SETUP: phase_last = (int'(cnt) + 1 >= CS_SETUP_CYC);
      ST_HOLD:  phase_last = (int'(cnt) + 1 >= CS_HOLD_CYC);
      ST_GAP:   phase_last = (int'(cnt) + 1 >= CS_GAP_CYC);
      default:  phase_last = 1'b0;
    endcase
  end

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      win_idx   <= '0;
      len_q     <= '0;
      byte_cnt  <= '0;
      cnt       <= '0;
      grant     <= '0;
      tx_ack    <= '0;
      rx_valid  <= '0;
      txn_done  <= '0;
      ss_n      <= '1;
      rx_data   <= '0;
      m_start   <= 1'b0;
      m_tx_data <= '0;
      m_cpol    <= 1'b0;
      m_cpha    <= 1'b0;
    end else begin
      m_start  <= 1'b0;
      tx_ack   <= '0;
      rx_valid <= '0;
      txn_done <= '0;

      case (state)
        ST_IDLE: begin
          if (arb_valid) begin
            win_idx  <= arb_idx;
            len_q    <= req_len[arb_idx*LEN_W +: LEN_W];
            m_cpol   <= arb_mode[MODE_CPOL_BIT];
            m_cpha   <= arb_mode[MODE_CPHA_BIT];
            grant    <= arb_onehot;
            ss_n     <= ~arb_onehot;
            byte_cnt <= '0;
            cnt      <= '0;
            state    <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          if (phase_last) begin
            cnt   <= '0;
            state <= ST_LOAD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_LOAD: begin
          if (m_ready) begin
            m_start   <= 1'b1;
            m_tx_data <= req_tx_data[win_idx*8 +: 8];
            tx_ack    <= grant;
            state     <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (m_done) begin
            rx_data  <= m_rx_data;
            rx_valid <= grant;
            if (byte_cnt == len_q) begin
              cnt   <= '0;
              state <= ST_HOLD;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
              state    <= ST_LOAD;
            end
          end
        end

        ST_HOLD: begin
          if (phase_last) begin
            ss_n     <= '1;
            grant    <= '0;
            txn_done <= grant;
            rr_ptr   <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
            cnt      <= '0;
            state    <= ST_GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_GAP: begin
          if (phase_last) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
